// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: MIPS opcode/funct encodings,
// ALU operation codes, datapath widths and the controller state type.
package alu_issue_ctrl_pkg;

  localparam int DATA_W  = 32;
  localparam int INSTR_W = 32;
  localparam int OPRN_W  = 6;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_MULI  = 6'h1d;

  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  localparam logic [OPRN_W-1:0] OPRN_NOP = 6'h00;
  localparam logic [OPRN_W-1:0] OPRN_ADD = 6'h01;
  localparam logic [OPRN_W-1:0] OPRN_SUB = 6'h02;
  localparam logic [OPRN_W-1:0] OPRN_MUL = 6'h03;
  localparam logic [OPRN_W-1:0] OPRN_SRL = 6'h04;
  localparam logic [OPRN_W-1:0] OPRN_SLL = 6'h05;
  localparam logic [OPRN_W-1:0] OPRN_AND = 6'h06;
  localparam logic [OPRN_W-1:0] OPRN_OR  = 6'h07;
  localparam logic [OPRN_W-1:0] OPRN_NOR = 6'h08;
  localparam logic [OPRN_W-1:0] OPRN_SLT = 6'h09;

  localparam logic [DATA_W-1:0] LUI_SHIFT = 32'd16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_RESP
  } state_e;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
    return {{(DATA_W-16){1'b0}}, v};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS decode: instruction + register operands -> ALU operands,
// operation code and an illegal flag. No state, zero latency.
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [DATA_W-1:0]  rs_data_i,
  input  logic [DATA_W-1:0]  rt_data_i,
  output logic [DATA_W-1:0]  op1_o,
  output logic [DATA_W-1:0]  op2_o,
  output logic [OPRN_W-1:0]  oprn_o,
  output logic               illegal_o
);

  logic [5:0]  opcode;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        unused_reg_fields;

  assign opcode = instr_i[31:26];
  assign shamt  = instr_i[10:6];
  assign funct  = instr_i[5:0];
  assign imm    = instr_i[15:0];
  // Register specifiers are resolved upstream; only their data arrives here.
  assign unused_reg_fields = ^instr_i[25:16];

  always_comb begin
    op1_o     = rs_data_i;
    op2_o     = rt_data_i;
    oprn_o    = OPRN_NOP;
    illegal_o = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD: oprn_o = OPRN_ADD;
          FN_SUB: oprn_o = OPRN_SUB;
          FN_MUL: oprn_o = OPRN_MUL;
          FN_AND: oprn_o = OPRN_AND;
          FN_OR:  oprn_o = OPRN_OR;
          FN_NOR: oprn_o = OPRN_NOR;
          FN_SLT: oprn_o = OPRN_SLT;
          FN_SRL: begin
            oprn_o = OPRN_SRL;
            op2_o  = {{(DATA_W-5){1'b0}}, shamt};
          end
          FN_SLL: begin
            oprn_o = OPRN_SLL;
            op2_o  = {{(DATA_W-5){1'b0}}, shamt};
          end
          default: illegal_o = 1'b1;
        endcase
      end
      OPC_ADDI: begin oprn_o = OPRN_ADD; op2_o = sext16(imm); end
      OPC_MULI: begin oprn_o = OPRN_MUL; op2_o = sext16(imm); end
      OPC_SLTI: begin oprn_o = OPRN_SLT; op2_o = sext16(imm); end
      OPC_ANDI: begin oprn_o = OPRN_AND; op2_o = zext16(imm); end
      OPC_ORI:  begin oprn_o = OPRN_OR;  op2_o = zext16(imm); end
      OPC_LUI: begin
        oprn_o = OPRN_SLL;
        op1_o  = zext16(imm);
        op2_o  = LUI_SHIFT;
      end
      default: illegal_o = 1'b1;
    endcase
    if (illegal_o) begin
      oprn_o = OPRN_NOP;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded instruction to an external ALU, holds operands for SETTLE_CYCLES,
// captures the result and presents it on a valid/ready response port.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [DATA_W-1:0]  rs_data_i,
  input  logic [DATA_W-1:0]  rt_data_i,
  output logic [DATA_W-1:0]  op1_o,
  output logic [DATA_W-1:0]  op2_o,
  output logic [OPRN_W-1:0]  oprn_o,
  input  logic [DATA_W-1:0]  alu_out_i,
  input  logic [DATA_W-1:0]  alu_zero_i,
  output logic [DATA_W-1:0]  res_o,
  output logic               res_zero_o,
  output logic               res_err_o,
  output logic               res_valid_o,
  input  logic               res_ready_i
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic [OPRN_W-1:0]   oprn_q, oprn_d;
  logic                res_zero_q, res_zero_d, res_err_q, res_err_d;
  logic                req_ready;
  logic [DATA_W-1:0]   dec_op1, dec_op2;
  logic [OPRN_W-1:0]   dec_oprn;
  logic                dec_illegal;
  logic                unused_zero_hi;

  assign unused_zero_hi = ^alu_zero_i[DATA_W-1:1];

  alu_op_decode u_decode (
    .instr_i   (instr_i),
    .rs_data_i (rs_data_i),
    .rt_data_i (rt_data_i),
    .op1_o     (dec_op1),
    .op2_o     (dec_op2),
    .oprn_o    (dec_oprn),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    oprn_d     = oprn_q;
    res_d      = res_q;
    res_zero_d = res_zero_q;
    res_err_d  = res_err_q;
    req_ready  = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_DRIVE: begin
        if (cnt_q == 4'd0) begin
          res_d      = alu_out_i;
          res_zero_d = alu_zero_i[0];
          res_err_d  = 1'b0;
          oprn_d     = OPRN_NOP;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (res_ready_i) begin
          req_ready = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rst_n_i) begin
      req_ready = 1'b0;
    end
    // A retiring response and a new request may share the same edge.
    if (req_valid_i && req_ready) begin
      if (dec_illegal) begin
        state_d    = ST_RESP;
        res_d      = '0;
        res_zero_d = 1'b0;
        res_err_d  = 1'b1;
        oprn_d     = OPRN_NOP;
      end else begin
        state_d = ST_DRIVE;
        cnt_d   = CNT_LOAD;
        op1_d   = dec_op1;
        op2_d   = dec_op2;
        oprn_d  = dec_oprn;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      op1_q      <= '0;
      op2_q      <= '0;
      oprn_q     <= OPRN_NOP;
      res_q      <= '0;
      res_zero_q <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      oprn_q     <= oprn_d;
      res_q      <= res_d;
      res_zero_q <= res_zero_d;
      res_err_q  <= res_err_d;
    end
  end

  assign req_ready_o = req_ready;
  assign res_valid_o = (state_q == ST_RESP);
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign oprn_o      = oprn_q;
  assign res_o       = res_q;
  assign res_zero_o  = res_zero_q;
  assign res_err_o   = res_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (SETTLE_CYCLES 1 and 4) each driving a behavioural ALU.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst1, rst4;
  logic        req_valid, res_ready;
  logic [31:0] instr, rs, rt;
  int          sel;
  int          checks = 0;
  int          errors = 0;

  logic        rr1, rv1, z1, e1, rr4, rv4, z4, e4;
  logic [31:0] op1_1, op2_1, res1, alu1, op1_4, op2_4, res4, alu4;
  logic [5:0]  oprn1, oprn4;

  logic        o_rr, o_rv, o_z, o_e;
  logic [31:0] o_op1, o_op2, o_res;
  logic [5:0]  o_oprn;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OPRN_ADD: return a + b;
      OPRN_SUB: return a - b;
      OPRN_MUL: return a * b;
      OPRN_SRL: return a >> b[4:0];
      OPRN_SLL: return a << b[4:0];
      OPRN_AND: return a & b;
      OPRN_OR:  return a | b;
      OPRN_NOR: return ~(a | b);
      OPRN_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  assign alu1 = alu_f(oprn1, op1_1, op2_1);
  assign alu4 = alu_f(oprn4, op1_4, op2_4);

  alu_issue_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clk_i(clk), .rst_n_i(rst1), .req_valid_i(req_valid), .req_ready_o(rr1),
    .instr_i(instr), .rs_data_i(rs), .rt_data_i(rt),
    .op1_o(op1_1), .op2_o(op2_1), .oprn_o(oprn1),
    .alu_out_i(alu1), .alu_zero_i({31'd0, alu1 == 32'd0}),
    .res_o(res1), .res_zero_o(z1), .res_err_o(e1), .res_valid_o(rv1), .res_ready_i(res_ready)
  );

  alu_issue_ctrl #(.SETTLE_CYCLES(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst4), .req_valid_i(req_valid), .req_ready_o(rr4),
    .instr_i(instr), .rs_data_i(rs), .rt_data_i(rt),
    .op1_o(op1_4), .op2_o(op2_4), .oprn_o(oprn4),
    .alu_out_i(alu4), .alu_zero_i({31'd0, alu4 == 32'd0}),
    .res_o(res4), .res_zero_o(z4), .res_err_o(e4), .res_valid_o(rv4), .res_ready_i(res_ready)
  );

  always_comb begin
    o_rr = rr1; o_rv = rv1; o_z = z1; o_e = e1;
    o_op1 = op1_1; o_op2 = op2_1; o_res = res1; o_oprn = oprn1;
    if (sel == 1) begin
      o_rr = rr4; o_rv = rv4; o_z = z4; o_e = e4;
      o_op1 = op1_4; o_op2 = op2_4; o_res = res4; o_oprn = oprn4;
    end
  end

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 15'h0000, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [15:0] imm);
    return {opc, 10'h000, imm};
  endfunction

  // One transaction: latency counted in cycles after the accepting edge; drv counts cycles OPRN is non-zero.
  task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int drv, output logic [31:0] r,
                        output logic z, output logic e);
    @(negedge clk);
    instr = ins; rs = a; rt = b; req_valid = 1'b1; res_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    drv = (o_oprn != 6'h00) ? 1 : 0;
    while (!o_rv && lat < 40) begin
      @(negedge clk);
      lat++;
      if (o_oprn != 6'h00) drv++;
    end
    r = o_res; z = o_z; e = o_e;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({o_rv, o_z, o_e, o_rr, o_oprn, o_op1, o_op2, o_res} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rv=%0b z=%0b e=%0b rr=%0b oprn=%0h op1=%0h op2=%0h res=%0h want all 0",
               o_rv, o_z, o_e, o_rr, o_oprn, o_op1, o_op2, o_res);
    end
    rst1 = 1'b1;
    #1;
    checks++;
    if (o_rr !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b want 1", o_rr); end
  endtask

  task automatic test_add();
    int lat, drv; logic [31:0] r; logic z, e;
    run_op(rtype(FN_ADD, 5'd0), 32'd5, 32'd7, lat, drv, r, z, e);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d want 2", lat); end
    checks++;
    if (drv !== 1) begin errors++; $display("FAIL add_drive_cycles got %0d want 1", drv); end
    checks++;
    if ({r, z, e} !== {32'd12, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_result res=%0d z=%0b e=%0b want 12 0 0", r, z, e);
    end
  endtask

  task automatic test_sub_zero();
    int lat, drv; logic [31:0] r; logic z, e;
    run_op(rtype(FN_SUB, 5'd0), 32'd9, 32'd9, lat, drv, r, z, e);
    checks++;
    if ({r, z, e} !== {32'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_zero res=%0d z=%0b e=%0b want 0 1 0", r, z, e);
    end
  endtask

  task automatic test_alu_ops();
    int lat, drv; logic [31:0] r; logic z, e;
    logic [31:0] ins [6];
    logic [31:0] a [6];
    logic [31:0] b [6];
    logic [31:0] exp [6];
    ins[0] = itype(OPC_ADDI, 16'hfffe);   a[0] = 32'd10;        b[0] = 32'd0; exp[0] = 32'd8;
    ins[1] = itype(OPC_LUI, 16'h1234);    a[1] = 32'hdeadbeef;  b[1] = 32'd0; exp[1] = 32'h12340000;
    ins[2] = itype(OPC_ORI, 16'h8000);    a[2] = 32'd0;         b[2] = 32'd0; exp[2] = 32'h00008000;
    ins[3] = rtype(FN_SRL, 5'd4);         a[3] = 32'h80;        b[3] = 32'd99; exp[3] = 32'h8;
    ins[4] = rtype(FN_SLT, 5'd0);         a[4] = 32'hffffffff;  b[4] = 32'd1; exp[4] = 32'd1;
    ins[5] = itype(OPC_ANDI, 16'hf0f0);   a[5] = 32'hffff3c3c;  b[5] = 32'd0; exp[5] = 32'h00003030;
    for (int i = 0; i < 6; i++) begin
      run_op(ins[i], a[i], b[i], lat, drv, r, z, e);
      checks++;
      if (r !== exp[i] || e !== 1'b0) begin
        errors++; $display("FAIL alu_op_%0d res=%h err=%0b want %h 0", i, r, e, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    int lat, drv; logic [31:0] r; logic z, e;
    run_op(rtype(6'h3f, 5'd0), 32'd3, 32'd4, lat, drv, r, z, e);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL illegal_latency got %0d want 1", lat); end
    checks++;
    if (drv !== 0) begin errors++; $display("FAIL illegal_oprn_cycles got %0d want 0", drv); end
    checks++;
    if ({r, z, e} !== {32'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL illegal_result res=%0h z=%0b e=%0b want 0 0 1", r, z, e);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    @(negedge clk);
    instr = rtype(FN_ADD, 5'd0); rs = 32'd5; rt = 32'd7; req_valid = 1'b1; res_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!(o_rv === 1'b1 && o_res === 32'd12 && o_rr === 1'b0)) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL backpressure_hold bad_cycles=%0d want 0", bad); end
    instr = rtype(FN_SUB, 5'd0); rs = 32'd20; rt = 32'd3; req_valid = 1'b1; res_ready = 1'b1;
    #1;
    checks++;
    if (o_rr !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0b want 1", o_rr); end
    @(negedge clk);
    req_valid = 1'b0; res_ready = 1'b0;
    checks++;
    if (o_rv !== 1'b0 || o_oprn !== OPRN_SUB) begin
      errors++; $display("FAIL b2b_accept rv=%0b oprn=%0h want 0 02", o_rv, o_oprn);
    end
    @(negedge clk);
    checks++;
    if (o_rv !== 1'b1 || o_res !== 32'd17) begin
      errors++; $display("FAIL b2b_result rv=%0b res=%0d want 1 17", o_rv, o_res);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_settle4();
    int lat, drv; logic [31:0] r; logic z, e;
    rst1 = 1'b0; sel = 1; rst4 = 1'b1;
    run_op(itype(OPC_MULI, 16'hfffd), 32'd6, 32'd0, lat, drv, r, z, e);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL settle4_latency got %0d want 5", lat); end
    checks++;
    if (drv !== 4) begin errors++; $display("FAIL settle4_drive_cycles got %0d want 4", drv); end
    checks++;
    if (r !== 32'hffffffee) begin errors++; $display("FAIL settle4_result got %h want ffffffee", r); end
  endtask

  task automatic test_reset_mid_drive();
    int pulses = 0;
    @(negedge clk);
    instr = rtype(FN_ADD, 5'd0); rs = 32'd5; rt = 32'd7; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_oprn !== OPRN_ADD || o_op1 !== 32'd5) begin
      errors++; $display("FAIL middrive_state oprn=%0h op1=%0d want 01 5", o_oprn, o_op1);
    end
    rst4 = 1'b0;
    #1;
    checks++;
    if (o_rr !== 1'b0) begin errors++; $display("FAIL ready_in_reset got %0b want 0", o_rr); end
    @(negedge clk);
    checks++;
    if ({o_rv, o_z, o_e, o_oprn, o_op1, o_op2, o_res} !== '0) begin
      errors++; $display("FAIL middrive_reset rv=%0b oprn=%0h op1=%0h op2=%0h res=%0h want all 0",
                         o_rv, o_oprn, o_op1, o_op2, o_res);
    end
    rst4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_rv) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL middrive_no_result pulses=%0d want 0", pulses); end
  endtask

  initial begin
    rst1 = 1'b0; rst4 = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    instr = 32'd0; rs = 32'd0; rt = 32'd0; sel = 0;
    test_reset();
    test_add();
    test_sub_zero();
    test_alu_ops();
    test_illegal();
    test_back_to_back();
    test_settle4();
    test_reset_mid_drive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
